// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the countdown timer.
// FSM state encodings, common with the up-counter harness.
package countdown_timer_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_EXPIRED = 2'd2;

endpackage

// File: rtl/countdown_timer_if.sv
// Load handshake bundle for the countdown timer.
// Producer drives valid/value, timer drives ready.
interface countdown_timer_if #(
  parameter int WIDTH = 16
);

  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_value;

  modport master (
    output load_valid,
    output load_value,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_value,
    output load_ready
  );

endinterface

// File: rtl/countdown_timer_sat_down_counter.sv
// Saturating down-counter: clamp on load, stops at 0.
// Load takes priority over decrement.
module sat_down_counter #(
  parameter int WIDTH      = 16,
  parameter int MAX_AMOUNT = 22
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             one
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_AMOUNT);

  logic [WIDTH-1:0] clamped;

  assign clamped = (load_val > MAX_V) ? MAX_V : load_val;
  assign zero    = (count == '0);
  assign one     = (count == WIDTH'(1));

  // count register: load clamped value, else decrement without wrap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= MAX_V;
    end else if (load) begin
      count <= clamped;
    end else if (dec && !zero) begin
      count <= count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Loadable saturating countdown timer with auto-reload.
// FSM, reload register and load handshake live here.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int MAX_AMOUNT = 22
) (
  input  logic              clk,
  input  logic              reset,
  countdown_timer_if.slave  ld,
  input  logic              start,
  input  logic              abort,
  input  logic              enable,
  input  logic              auto_reload,
  output logic [WIDTH-1:0]  count,
  output logic              busy,
  output logic              done
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_AMOUNT);

  logic [1:0]       state;
  logic [1:0]       state_n;
  logic [WIDTH-1:0] reload_reg;
  logic [WIDTH-1:0] reload_n;
  logic [WIDTH-1:0] clamped;
  logic [WIDTH-1:0] cnt_val;
  logic             cnt_ld;
  logic             cnt_dec;
  logic             zero;
  logic             one;
  logic             done_n;
  // set while RUN sits at 0 after its done pulse already fired
  logic             fired;
  logic             fired_n;
  logic             load_fire;
  logic             can_reload;

  assign ld.load_ready = (state != ST_RUN);
  assign busy          = (state == ST_RUN);
  assign load_fire     = ld.load_valid && ld.load_ready;
  assign clamped       = (ld.load_value > MAX_V) ? MAX_V : ld.load_value;
  assign can_reload    = (reload_reg != '0);

  sat_down_counter #(
    .WIDTH      (WIDTH),
    .MAX_AMOUNT (MAX_AMOUNT)
  ) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_ld),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .count    (count),
    .zero     (zero),
    .one      (one)
  );

  // next-state, counter control and done decode
  always_comb begin
    state_n  = state;
    reload_n = reload_reg;
    cnt_ld   = 1'b0;
    cnt_val  = clamped;
    cnt_dec  = 1'b0;
    done_n   = 1'b0;
    fired_n  = 1'b0;
    if (load_fire) begin
      cnt_ld   = 1'b1;
      reload_n = clamped;
    end
    case (state)
      ST_IDLE: begin
        if (abort)      state_n = ST_IDLE;
        else if (start) state_n = ST_RUN;
      end
      ST_EXPIRED: begin
        if (abort) begin
          state_n = ST_IDLE;
        end else if (start) begin
          state_n = ST_RUN;
          if (!load_fire && can_reload) begin
            cnt_ld  = 1'b1;
            cnt_val = reload_reg;
          end
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_n = ST_IDLE;
        end else if (zero && !fired) begin
          done_n = 1'b1;
          if (auto_reload && can_reload) begin
            cnt_ld  = 1'b1;
            cnt_val = reload_reg;
          end else begin
            state_n = ST_EXPIRED;
          end
        end else if (zero) begin
          if (!enable) begin
            fired_n = 1'b1;
          end else if (auto_reload && can_reload) begin
            cnt_ld  = 1'b1;
            cnt_val = reload_reg;
          end else begin
            state_n = ST_EXPIRED;
          end
        end else if (enable) begin
          cnt_dec = 1'b1;
          if (one) begin
            done_n = 1'b1;
            if (auto_reload) fired_n = 1'b1;
            else             state_n = ST_EXPIRED;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // state, reload value, done pulse and zero-ack flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      reload_reg <= MAX_V;
      done       <= 1'b0;
      fired      <= 1'b0;
    end else begin
      state      <= state_n;
      reload_reg <= reload_n;
      done       <= done_n;
      fired      <= fired_n;
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer.
// Inputs change and outputs are sampled on the falling edge.
module tb_countdown_timer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic        enable;
  logic        auto_reload;
  logic [15:0] count;
  logic        busy;
  logic        done;
  int          checks;
  int          errors;

  countdown_timer_if #(.WIDTH(16)) ifc ();

  countdown_timer #(
    .WIDTH      (16),
    .MAX_AMOUNT (22)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ld          (ifc.slave),
    .start       (start),
    .abort       (abort),
    .enable      (enable),
    .auto_reload (auto_reload),
    .count       (count),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int exp;
    int ar_seq[8];
    checks         = 0;
    errors         = 0;
    reset          = 1'b1;
    start          = 1'b0;
    abort          = 1'b0;
    enable         = 1'b0;
    auto_reload    = 1'b0;
    ifc.load_valid = 1'b0;
    ifc.load_value = 16'd0;
    step();
    step();
    chk("rst_count", count, 22);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", ifc.load_ready, 1);
    reset = 1'b0;

    // 1: load 5, count to 0
    ifc.load_valid = 1'b1;
    ifc.load_value = 16'd5;
    step();
    ifc.load_valid = 1'b0;
    chk("t1_load", count, 5);
    chk("t1_idle", busy, 0);
    start  = 1'b1;
    enable = 1'b1;
    step();
    start = 1'b0;
    chk("t1_run", busy, 1);
    chk("t1_first", count, 5);
    for (int i = 4; i >= 0; i--) begin
      step();
      chk("t1_count", count, i);
      chk("t1_done", done, (i == 0) ? 1 : 0);
    end
    chk("t1_expired", busy, 0);
    step();
    chk("t1_done_once", done, 0);
    chk("t1_hold0", count, 0);

    // 2: clamp 100 to 22, no wrap
    ifc.load_valid = 1'b1;
    ifc.load_value = 16'd100;
    step();
    ifc.load_valid = 1'b0;
    chk("t2_clamp", count, 22);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t2_run", busy, 1);
    exp = 22;
    for (int i = 0; i < 30; i++) begin
      exp = (exp > 0) ? exp - 1 : 0;
      step();
      chk("t2_count", count, exp);
    end
    chk("t2_expired", busy, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t2_reload22", count, 22);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t2_abort_idle", busy, 0);
    chk("t2_abort_hold", count, 22);

    // 3: auto-reload of 3
    auto_reload    = 1'b1;
    ifc.load_valid = 1'b1;
    ifc.load_value = 16'd3;
    step();
    ifc.load_valid = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t3_start", count, 3);
    ar_seq = '{2, 1, 0, 3, 2, 1, 0, 3};
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t3_count", count, ar_seq[i]);
      chk("t3_done", done, (ar_seq[i] == 0) ? 1 : 0);
      chk("t3_busy", busy, 1);
    end
    abort = 1'b1;
    step();
    abort       = 1'b0;
    auto_reload = 1'b0;
    chk("t3_abort", busy, 0);

    // 4: enable gating, load refused in RUN
    ifc.load_valid = 1'b1;
    ifc.load_value = 16'd4;
    step();
    ifc.load_valid = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t4_start", count, 4);
    enable = 1'b0;
    step();
    chk("t4_en0", count, 4);
    enable = 1'b1;
    step();
    chk("t4_en1", count, 3);
    enable = 1'b0;
    ifc.load_valid = 1'b1;
    ifc.load_value = 16'd9;
    #1;
    chk("t4_ready_run", ifc.load_ready, 0);
    step();
    ifc.load_valid = 1'b0;
    chk("t4_ignored", count, 3);
    enable = 1'b1;
    step();
    chk("t4_en1b", count, 2);

    // 5: abort at 2 then resume
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t5_idle", busy, 0);
    chk("t5_hold", count, 2);
    chk("t5_nodone", done, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t5_resume", count, 2);
    chk("t5_busy", busy, 1);
    step();
    chk("t5_one", count, 1);
    step();
    chk("t5_zero", count, 0);
    chk("t5_done", done, 1);

    // 6: async reset mid-run
    ifc.load_valid = 1'b1;
    ifc.load_value = 16'd10;
    start          = 1'b1;
    step();
    ifc.load_valid = 1'b0;
    start          = 1'b0;
    step();
    chk("t6_pre", count, 9);
    #2 reset = 1'b1;
    #1;
    chk("t6_count", count, 22);
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    @(negedge clk);
    reset = 1'b0;

    // 7: load 0 with start
    ifc.load_valid = 1'b1;
    ifc.load_value = 16'd0;
    start          = 1'b1;
    step();
    ifc.load_valid = 1'b0;
    start          = 1'b0;
    chk("t7_count", count, 0);
    chk("t7_busy", busy, 1);
    chk("t7_nodone", done, 0);
    step();
    chk("t7_done", done, 1);
    chk("t7_expired", busy, 0);
    step();
    chk("t7_done_off", done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
